// File: rtl/fmul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control and a pass-through tag.
// Define FMUL_PIPE_FLAGS_EN to add registered ovf/udf outputs aligned with y.
module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [EXP_W+MAN_W:0]     x1,
    input  logic [EXP_W+MAN_W:0]     x2,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [EXP_W+MAN_W:0]     y,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef FMUL_PIPE_FLAGS_EN
    ,
    output logic                     ovf,
    output logic                     udf
`endif
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    logic s1_valid_reg;
    logic s2_valid_reg;
    logic out_valid_reg;
    logic s1_load;
    logic s2_load;
    logic s3_load;

    // Each stage loads when empty or when its successor drains it this cycle.
    assign s3_load  = !out_valid_reg || out_ready;
    assign s2_load  = !s2_valid_reg || s3_load;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;

    logic [W-1:0]     op      [2];
    logic [EXP_W-1:0] op_exp  [2];
    logic [MW-1:0]    op_man  [2];
    logic             op_zero [2];

    assign op[0] = x1;
    assign op[1] = x2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign op_exp[gi]  = op[gi][W-2 -: EXP_W];
            assign op_man[gi]  = {1'b1, op[gi][MAN_W-1:0]};
            assign op_zero[gi] = (op_exp[gi] == '0);
        end
    endgenerate

    logic             s1_sign_reg;
    logic             s1_zero_reg;
    logic [EW-1:0]    s1_esum_reg;
    logic [MW-1:0]    s1_ma_reg;
    logic [MW-1:0]    s1_mb_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_zero_reg  <= 1'b0;
            s1_esum_reg  <= '0;
            s1_ma_reg    <= '0;
            s1_mb_reg    <= '0;
            s1_tag_reg   <= '0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            s1_sign_reg  <= op[0][W-1] ^ op[1][W-1];
            s1_zero_reg  <= op_zero[0] | op_zero[1];
            s1_esum_reg  <= EW'(op_exp[0]) + EW'(op_exp[1]);
            s1_ma_reg    <= op_man[0];
            s1_mb_reg    <= op_man[1];
            s1_tag_reg   <= in_tag;
        end
    end

    logic             s2_sign_reg;
    logic             s2_zero_reg;
    logic [EW-1:0]    s2_esum_reg;
    logic [PW-1:0]    s2_prod_reg;
    logic [TAG_W-1:0] s2_tag_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid_reg <= 1'b0;
            s2_sign_reg  <= 1'b0;
            s2_zero_reg  <= 1'b0;
            s2_esum_reg  <= '0;
            s2_prod_reg  <= '0;
            s2_tag_reg   <= '0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            s2_sign_reg  <= s1_sign_reg;
            s2_zero_reg  <= s1_zero_reg;
            s2_esum_reg  <= s1_esum_reg;
            s2_prod_reg  <= PW'(s1_ma_reg) * PW'(s1_mb_reg);
            s2_tag_reg   <= s1_tag_reg;
        end
    end

    logic             norm;
    logic [MAN_W-1:0] kept;
    logic             rnd;
    logic [MAN_W:0]   man_rnd;
    logic             carry;
    logic [EW-1:0]    e_res;
    logic             is_ovf;
    logic             is_udf;
    logic [W-1:0]     y_next;

    // Bits below the round position never influence ties-away rounding.
    logic unused_prod_lsbs;
    assign unused_prod_lsbs = ^s2_prod_reg[MAN_W-2:0];

    always_comb begin
        norm = s2_prod_reg[PW-1];
        if (norm) begin
            kept = s2_prod_reg[PW-2 -: MAN_W];
            rnd  = s2_prod_reg[MAN_W];
        end else begin
            kept = s2_prod_reg[PW-3 -: MAN_W];
            rnd  = s2_prod_reg[MAN_W-1];
        end
        man_rnd = {1'b0, kept} + {{MAN_W{1'b0}}, rnd};
        carry   = man_rnd[MAN_W];
        // Intermediate sum may wrap, but the biased result always fits in EW signed bits.
        e_res   = s2_esum_reg + EW'(norm) + EW'(carry) - BIAS;
        is_ovf  = !e_res[EW-1] && (e_res >= EMAX);
        is_udf  = e_res[EW-1] || (e_res == '0);

        y_next = {s2_sign_reg, {(W-1){1'b0}}};
        if (!s2_zero_reg) begin
            if (is_ovf) begin
                y_next = {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (!is_udf) begin
                y_next = {s2_sign_reg, e_res[EXP_W-1:0], man_rnd[MAN_W-1:0]};
            end
        end
    end

    logic [W-1:0]     y_reg;
    logic [TAG_W-1:0] out_tag_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            out_tag_reg   <= '0;
        end else if (s3_load) begin
            out_valid_reg <= s2_valid_reg;
            y_reg         <= y_next;
            out_tag_reg   <= s2_tag_reg;
        end
    end

    assign y         = y_reg;
    assign out_tag   = out_tag_reg;
    assign out_valid = out_valid_reg;

`ifdef FMUL_PIPE_FLAGS_EN
    logic ovf_reg;
    logic udf_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else if (s3_load) begin
            ovf_reg <= !s2_zero_reg && is_ovf;
            udf_reg <= !s2_zero_reg && is_udf;
        end
    end

    assign ovf = ovf_reg;
    assign udf = udf_reg;
`endif

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe: directed binary32 cases, backpressure, random stream and mid-stall reset.
module tb_fmul_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 5;
    localparam int W     = 32;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [W-1:0]     x1 = '0;
    logic [W-1:0]     x2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     y;
    logic [TAG_W-1:0] out_tag;
    logic             out_valid;
    logic             out_ready = 1'b0;
`ifdef FMUL_PIPE_FLAGS_EN
    logic             ovf;
    logic             udf;
`endif

    fmul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .x1        (x1),
        .x2        (x2),
        .in_tag    (in_tag),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_tag   (out_tag),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FMUL_PIPE_FLAGS_EN
        ,
        .ovf       (ovf),
        .udf       (udf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     y;
        logic             ovf;
        logic             udf;
    } exp_t;

    exp_t             sb[$];
    int               total = 0;
    int               bad = 0;
    logic             stall_prev = 1'b0;
    logic [W-1:0]     y_prev = '0;
    logic [TAG_W-1:0] tag_prev = '0;
    logic             in_xfer = 1'b0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Reference: exact product in double precision, then ties-away rounding to 23 bits.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        exp_t        r;
        logic        s;
        logic [63:0] da;
        logic [63:0] db;
        logic [63:0] dp;
        logic [23:0] mr;
        int          de;
        int          e;
        s = a[31] ^ b[31];
        r.tag = t;
        r.ovf = 1'b0;
        r.udf = 1'b0;
        r.y   = {s, 31'b0};
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return r;
        da = {1'b0, 11'(int'(a[30:23]) + 896), a[22:0], 29'b0};
        db = {1'b0, 11'(int'(b[30:23]) + 896), b[22:0], 29'b0};
        dp = $realtobits($bitstoreal(da) * $bitstoreal(db));
        de = int'(dp[62:52]);
        mr = {1'b0, dp[51:29]} + 24'(dp[28]);
        if (mr[23]) begin
            mr = 24'd0;
            de++;
        end
        e = de - 896;
        if (e >= 255) begin
            r.y = {s, 8'hFF, 23'b0};
            r.ovf = 1'b1;
        end else if (e <= 0) begin
            r.udf = 1'b1;
        end else begin
            r.y = {s, e[7:0], mr[22:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_norm();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(64, 190));
        return r;
    endfunction

    // One clock: observe handshakes mid-cycle, then advance to just after the next edge.
    task automatic step();
        exp_t e;
        #2;
        in_xfer = rstn && in_valid && in_ready;
        if (rstn && stall_prev) begin
            check("hold_y", 64'(y), 64'(y_prev));
            check("hold_tag", 64'(out_tag), 64'(tag_prev));
            check("hold_valid", 64'(out_valid), 64'(1));
        end
        if (rstn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                $display("out tag=%0d y=%08h exp_tag=%0d exp_y=%08h", out_tag, y, e.tag, e.y);
                check("y", 64'(y), 64'(e.y));
                check("tag", 64'(out_tag), 64'(e.tag));
`ifdef FMUL_PIPE_FLAGS_EN
                check("ovf", 64'(ovf), 64'(e.ovf));
                check("udf", 64'(udf), 64'(e.udf));
`endif
            end
        end
        if (in_xfer) sb.push_back(model(x1, x2, in_tag));
        stall_prev = rstn && out_valid && !out_ready;
        y_prev = y;
        tag_prev = out_tag;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                         input logic [31:0] yexp, input string name);
        int n;
        out_ready = 1'b1;
        x1 = a;
        x2 = b;
        in_tag = t;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({name, "_acc"}, 64'(in_xfer), 64'(1));
        n = 1;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check({name, "_lat"}, 64'(n), 64'(3));
        check({name, "_y"}, 64'(y), 64'(yexp));
        check({name, "_tag"}, 64'(out_tag), 64'(t));
        step();
        check({name, "_1cyc"}, 64'(out_valid), 64'(0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int k;
        int cnt;

        // Reset
        rstn = 1'b0;
        step();
        step();
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_y", 64'(y), 64'(0));
        check("rst_tag", 64'(out_tag), 64'(0));
        rstn = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed arithmetic
        do_op(32'h3FC00000, 32'h40000000, 5'd7, 32'h40400000, "basic");
        do_op(32'h3F800001, 32'h3F800001, 5'd8, 32'h3F800002, "round");
        do_op(32'h3F800800, 32'h3F800800, 5'd9, 32'h3F801001, "tie");
        do_op(32'h7F000000, 32'h7F000000, 5'd10, 32'h7F800000, "ovf");
        do_op(32'h00800000, 32'h00800000, 5'd11, 32'h00000000, "udf");
        do_op(32'h80000001, 32'h3F800000, 5'd12, 32'h80000000, "subn");
        do_op(32'hC0000000, 32'h3FC00000, 5'd13, 32'hC0400000, "neg");

        // Backpressure: only three operations fit while the consumer stalls
        out_ready = 1'b0;
        k = 1;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_tag = 5'(k);
            x1 = 32'h3F800000 | 32'(k);
            x2 = 32'h40000000 | 32'(k << 4);
            step();
            if (in_xfer) k++;
        end
        check("bp_accepted", 64'(k - 1), 64'(3));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        for (int c = 0; c < 20 && k <= 5; c++) begin
            in_valid = 1'b1;
            in_tag = 5'(k);
            x1 = 32'h3F800000 | 32'(k);
            x2 = 32'h40000000 | 32'(k << 4);
            step();
            if (in_xfer) k++;
        end
        check("bp_all_accepted", 64'(k - 1), 64'(5));
        drain();

        // Random stream with random valid/ready
        cnt = 0;
        in_tag = 5'd0;
        in_valid = ($urandom_range(0, 3) != 0);
        x1 = rnd_norm();
        x2 = rnd_norm();
        for (int c = 0; c < 3000 && cnt < 100; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (in_xfer) cnt++;
            if (in_xfer || !in_valid) begin
                if (in_xfer) in_tag = in_tag + 5'd1;
                in_valid = (cnt < 100) && ($urandom_range(0, 3) != 0);
                x1 = rnd_norm();
                x2 = rnd_norm();
            end
        end
        check("stream_count", 64'(cnt), 64'(100));
        drain();

        // Reset in the middle of a full stall
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            x1 = rnd_norm();
            x2 = rnd_norm();
            in_tag = 5'(20 + c);
            step();
        end
        check("stall_full", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        rstn = 1'b0;
        step();
        sb.delete();
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_y", 64'(y), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("no_stale", 64'(out_valid), 64'(0));
        end
        do_op(32'h40400000, 32'h40400000, 5'd30, 32'h41100000, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Parametrised, pipelined floating-point multiplier. Successor to the single-cycle combinational binary32 multiplier.
- Generic exponent/mantissa widths, three registered stages, full valid/ready backpressure and a pass-through tag.
- Sits between the FPU issue logic and writeback; the tag carries the destination register index.

Parameters:
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23, stored mantissa width (hidden bit implicit).
- TAG_W, 5, sideband tag width, passed through unchanged.
- Derived, not overridable: W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  synchronous active-low reset
- x1  in  W  operand 1 {sign, exp, man}
- x2  in  W  operand 2
- in_tag  in  TAG_W  tag accompanying operands
- in_valid  in  1  operands/tag valid
- in_ready  out  1  block accepts this cycle
- y  out  W  product
- out_tag  out  TAG_W  tag of y
- out_valid  out  1  y/out_tag valid
- out_ready  in  1  consumer accepts y this cycle

Behaviour:
- Handshakes:
  - Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
  - y, out_tag, out_valid hold stable while out_valid && !out_ready.
- Pipeline (each stage has a valid bit):
  - S1: unpack; flush subnormals; sign = s1 xor s2; exponent sum e1+e2 in EXP_W+2 bits.
  - S2: (MAN_W+1)x(MAN_W+1) mantissa product, 2*MAN_W+2 bits.
  - S3: normalise, round, pack; S3 registers drive the outputs directly.
- Advance rule:
  - Stage k loads when it is empty or stage k+1 (or the consumer, for S3) takes its contents this cycle. Bubbles collapse.
  - in_ready = !S1.valid || S1 advances. It is combinational from out_ready through the chain.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput 1/cycle. Capacity 3 in flight. Strict FIFO order.
- Reset (rstn=0 at a clock edge):
  - All stage valids clear; y=0, out_tag=0, out_valid=0.
  - In-flight operations are discarded, including a mid-stall reset.
  - in_ready is 1 in the first cycle after reset.
- Arithmetic:
  - Operand exp == 0 means zero: the result magnitude is 0 and the sign is still the xor.
  - exp all-ones inputs get no special Inf/NaN handling; they are treated as normal numbers.
  - Product P in [1,4): if P >= 2, shift right 1 and add 1 to the exponent.
  - Round to nearest, ties away from zero: add the first discarded bit to the kept MAN_W bits.
  - A rounding carry-out (mantissa becomes 2.0) sets the mantissa to 0 and adds 1 to the exponent.
  - Biased result E = e1+e2+norm+roundcarry-bias, signed, EXP_W+2 bits.
  - E >= 2^EXP_W-1: overflow, output {sign, all-ones, 0} (infinity).
  - E <= 0: underflow, output {sign, 0, 0}. No subnormal results.
  - Otherwise output {sign, E[EXP_W-1:0], mantissa}.

Optional Feature:
- Macro: FMUL_PIPE_FLAGS_EN.
- When defined:
  - Adds outputs ovf (1 bit) and udf (1 bit), registered in S3 and aligned with y.
  - ovf=1 when the overflow rule fired. udf=1 when the underflow rule fired with both operands nonzero.
  - Both flags hold during a stall and reset to 0.
- When undefined: the ports do not exist and there is no logic for them.

Test Plan:
- Reset, then 0x3FC00000 x 0x40000000 with tag 7, out_ready=1 -> 3 cycles later y=0x40400000, out_tag=7, out_valid for 1 cycle.
- Rounding: 0x3F800001 x 0x3F800001 -> 0x3F800002. Tie: 0x3F800800 x 0x3F800800 -> 0x3F801001 (away from zero).
- Boundaries:
  - 0x7F000000 x 0x7F000000 -> 0x7F800000 (ovf=1 with flags).
  - 0x00800000 x 0x00800000 -> 0x00000000 (udf=1 with flags).
  - 0x80000001 x 0x3F800000 -> 0x80000000 (subnormal flushed, udf=0).
- Backpressure:
  - out_ready=0; offer 5 back-to-back ops (tags 1..5) -> in_ready drops after 3 accepted.
  - Then out_ready=1 -> tags 1..5 emerge in order, no loss or duplication, y stable while stalled.
- Stream: 100 random normal binary32 pairs with random in_valid/out_ready -> every result matches the reference model, tags in order.
- Reset mid-stall with 3 ops in flight -> out_valid=0 next cycle, no stale output after release; first post-reset op yields latency 3.
